window_3x3_gen: RTL and testbench

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/window_3x3_gen_pkg.sv | 17 +
 rtl/window_3x3_gen_line_buffer.sv | 28 ++
 rtl/window_3x3_gen.sv | 136 +++++++++++++
 tb/tb_window_3x3_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_gen_pkg.sv
// Shared constants and helpers for the 3x3 window generator and its line buffers.
package pkg_filter;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned COORD_W       = 12;
    localparam int unsigned MAX_IMG_WIDTH = 2048;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t COORD_MAX = {COORD_W{1'b1}};

    // Address width for a buffer of the given depth (at least one bit).
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One-line delay: circular RAM addressed by column, combinational read of the old entry
// followed by a write of the new one on the same accepted pixel.
module line_buffer
    import pkg_filter::*;
#(
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read sees the value from one line ago; the write lands at the clock edge.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 sliding window over a raster pixel stream, with registered outputs and one-cycle latency.
// Optional macro WINDOW_POS_EN adds win_col/win_row giving the centre pixel coordinate.
module window_3x3_gen
    import pkg_filter::*;
#(
    parameter int unsigned IMG_WIDTH = 640,
    parameter int unsigned DATA_W    = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] c1,
    output logic [DATA_W-1:0] c2,
    output logic [DATA_W-1:0] c3,
    output logic [DATA_W-1:0] c4,
    output logic [DATA_W-1:0] c5,
    output logic [DATA_W-1:0] c6,
    output logic [DATA_W-1:0] c7,
    output logic [DATA_W-1:0] c8,
    output logic [DATA_W-1:0] c9,
`ifdef WINDOW_POS_EN
    output logic [COORD_W-1:0] win_col,
    output logic [COORD_W-1:0] win_row,
`endif
    output logic              win_valid
);

    localparam int unsigned ADDR_W   = addr_w(IMG_WIDTH);
    localparam coord_t      LAST_COL = coord_t'(IMG_WIDTH - 1);

    if (IMG_WIDTH < 4 || IMG_WIDTH > MAX_IMG_WIDTH) begin : g_bad_width
        $error("window_3x3_gen: IMG_WIDTH out of range");
    end

    // col_q/row_q hold the position the next accepted pixel will take.
    coord_t col_q, row_q;
    coord_t cur_col, cur_row;
    coord_t nxt_col, nxt_row;
    logic   win_ok;

    always_comb begin
        cur_col = sof ? '0 : col_q;
        cur_row = sof ? '0 : row_q;
        nxt_col = cur_col + coord_t'(1);
        nxt_row = cur_row;
        if (cur_col == LAST_COL) begin
            nxt_col = '0;
            nxt_row = (cur_row == COORD_MAX) ? cur_row : cur_row + coord_t'(1);
        end
        win_ok = (cur_col >= coord_t'(2)) && (cur_row >= coord_t'(2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (pix_valid) begin
            col_q <= nxt_col;
            row_q <= nxt_row;
        end
    end

    logic [DATA_W-1:0] line1;
    logic [DATA_W-1:0] line2;
    logic [ADDR_W-1:0] lb_addr;

    assign lb_addr = cur_col[ADDR_W-1:0];

    line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_line1 (
        .clk   (clk),
        .we    (pix_valid),
        .addr  (lb_addr),
        .wdata (pix_in),
        .rdata (line1)
    );

    // Second buffer chains off the first to give a two-line delay.
    line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_line2 (
        .clk   (clk),
        .we    (pix_valid),
        .addr  (lb_addr),
        .wdata (line1),
        .rdata (line2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1        <= '0;
            c2        <= '0;
            c3        <= '0;
            c4        <= '0;
            c5        <= '0;
            c6        <= '0;
            c7        <= '0;
            c8        <= '0;
            c9        <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= pix_valid && win_ok;
            if (pix_valid) begin
                c1 <= c2;
                c2 <= c3;
                c3 <= line2;
                c4 <= c5;
                c5 <= c6;
                c6 <= line1;
                c7 <= c8;
                c8 <= c9;
                c9 <= pix_in;
            end
        end
    end

`ifdef WINDOW_POS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_col <= '0;
            win_row <= '0;
        end else if (pix_valid) begin
            win_col <= cur_col - coord_t'(1);
            win_row <= cur_row - coord_t'(1);
        end
    end
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen at IMG_WIDTH=4; pixel value = 16*row+col (plus a frame base).
module tb_window_3x3_gen;

    localparam int unsigned W  = 4;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic          sof;
    logic [DW-1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;
    logic          win_valid;
`ifdef WINDOW_POS_EN
    logic [11:0]   win_col;
    logic [11:0]   win_row;
`endif

    always #5 clk = ~clk;

    window_3x3_gen #(
        .IMG_WIDTH (W),
        .DATA_W    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .c4        (c4),
        .c5        (c5),
        .c6        (c6),
        .c7        (c7),
        .c8        (c8),
        .c9        (c9),
`ifdef WINDOW_POS_EN
        .win_col   (win_col),
        .win_row   (win_row),
`endif
        .win_valid (win_valid)
    );

    typedef struct {
        logic        valid;
        logic [71:0] win;
        logic [23:0] low;
        logic [7:0]  pix;
        logic [11:0] wc;
        logic [11:0] wr;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  img [0:7][0:3];
    int          mrow, mcol;
    logic [7:0]  m7, m8, m9;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses;
    logic [71:0] dut_win;

    assign dut_win = {c1, c2, c3, c4, c5, c6, c7, c8, c9};

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mrow = 0;
        mcol = 0;
        m7   = '0;
        m8   = '0;
        m9   = '0;
    endtask

    // Drive one cycle, push the expected result, then pop and compare after the edge.
    task automatic step(input logic v, input logic s, input logic [7:0] p);
        exp_t e;
        int   r, c;
        @(negedge clk);
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        e.valid = 1'b0;
        e.win   = '0;
        e.pix   = p;
        e.wc    = '0;
        e.wr    = '0;
        if (v) begin
            r = s ? 0 : mrow;
            c = s ? 0 : mcol;
            img[r % 8][c] = p;
            if (r >= 2 && c >= 2) begin
                e.valid = 1'b1;
                e.win   = {img[(r-2)%8][c-2], img[(r-2)%8][c-1], img[(r-2)%8][c],
                           img[(r-1)%8][c-2], img[(r-1)%8][c-1], img[(r-1)%8][c],
                           img[r%8][c-2],     img[r%8][c-1],     img[r%8][c]};
                e.wc    = 12'(c - 1);
                e.wr    = 12'(r - 1);
            end
            m7 = m8;
            m8 = m9;
            m9 = p;
            if (c == W - 1) begin
                mcol = 0;
                mrow = (r == 4095) ? r : r + 1;
            end else begin
                mcol = c + 1;
                mrow = r;
            end
        end
        e.low = {m7, m8, m9};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (win_valid === 1'b1) pulses++;
        check("win_valid", 72'(win_valid), 72'(e.valid));
        check("c7_c9", 72'({c7, c8, c9}), 72'(e.low));
        if (e.valid) begin
            check("window", dut_win, e.win);
            if (e.pix == 8'h22) check("win_after_22", dut_win, 72'h000102_101112_202122);
            if (e.pix == 8'h33) check("win_after_33", dut_win, 72'h111213_212223_313233);
`ifdef WINDOW_POS_EN
            check("win_pos", 72'({win_col, win_row}), 72'({e.wc, e.wr}));
            if (e.pix == 8'h22) check("pos_after_22", 72'({win_col, win_row}), 72'h001001);
`endif
        end
    endtask

    task automatic send_row(input int r, input int base, input logic first_sof);
        for (int c = 0; c < W; c++) begin
            step(1'b1, first_sof && (c == 0), 8'(base + 16 * r + c));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        sof       = 1'b0;
        pix_in    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 72'(win_valid), 72'd0);
        check("rst_win", dut_win, 72'd0);
        @(negedge clk);
        rst = 1'b0;

        // Four back-to-back rows: first window after 0x22, four windows total.
        pulses = 0;
        for (int r = 0; r < 4; r++) send_row(r, 0, r == 0);
        step(1'b0, 1'b0, 8'h00);
        check("frame_pulses", 72'(pulses), 72'd4);

        // Stall of three cycles after 0x21.
        pulses = 0;
        send_row(0, 0, 1'b1);
        send_row(1, 0, 1'b0);
        step(1'b1, 1'b0, 8'h20);
        step(1'b1, 1'b0, 8'h21);
        repeat (3) step(1'b0, 1'b1, 8'hEE);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h23);
        step(1'b0, 1'b0, 8'h00);
        check("stall_pulses", 72'(pulses), 72'd2);

        // Resync: sof arrives at row 2 col 1 carrying new-frame pixel (0,0).
        pulses = 0;
        send_row(0, 0, 1'b1);
        send_row(1, 0, 1'b0);
        step(1'b1, 1'b0, 8'h20);
        step(1'b1, 1'b1, 8'h80);
        for (int c = 1; c < W; c++) step(1'b1, 1'b0, 8'(8'h80 + c));
        send_row(1, 8'h80, 1'b0);
        send_row(2, 8'h80, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        check("resync_pulses", 72'(pulses), 72'd2);

        // Asynchronous reset mid row 2, right after a valid window.
        send_row(0, 0, 1'b1);
        send_row(1, 0, 1'b0);
        step(1'b1, 1'b0, 8'h20);
        step(1'b1, 1'b0, 8'h21);
        step(1'b1, 1'b0, 8'h22);
        pix_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 72'(win_valid), 72'd0);
        check("arst_win", dut_win, 72'd0);
`ifdef WINDOW_POS_EN
        check("arst_pos", 72'({win_col, win_row}), 72'd0);
`endif
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int r = 0; r < 3; r++) send_row(r, 0, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        check("post_rst_pulses", 72'(pulses), 72'd2);

        // Random stalls across a full frame.
        pulses = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 8'(16 * r + c));
                step(1'b1, (r == 0) && (c == 0), 8'(16 * r + c));
            end
        end
        step(1'b0, 1'b0, 8'h00);
        check("rand_pulses", 72'(pulses), 72'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
